// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial-in left shift register and its
// sequencing controller: default word width, statistics counter width,
// and the controller state encoding.
package shift_reg_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        HOLD
    } state_t;

endpackage

// File: rtl/shift_reg_seq_ctrl_if.sv
// Handshake bundle for shift_reg_seq_ctrl.
//   in_valid/in_word/in_ready        : word producer -> controller
//   out_valid/out_word/out_match/out_ready : controller -> result consumer
// slave  : controller view (accepts words, presents results)
// master : environment view (producer and consumer)
interface shift_reg_seq_ctrl_if #(
    parameter int WIDTH = shift_reg_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_word;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_word;
    logic             out_match;
    logic             out_ready;

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_match
    );

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_match
    );
endinterface

// File: rtl/shift_reg.sv
// Serial-in left shift register datapath driven by shift_reg_seq_ctrl.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset, clears the register
//   a         : serial input, enters at bit 0
//   shift_en  : shift left by one when high
//   shift_out : parallel register contents
module shift_reg #(
    parameter int WIDTH = shift_reg_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             shift_en,
    output logic [WIDTH-1:0] shift_out
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_out <= '0;
        end else if (shift_en) begin
            shift_out <= {shift_out[WIDTH-2:0], a};
        end
    end
endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencing controller for the serial-in left shift register.
// Accepts a WIDTH-bit word, shifts it out MSB-first for WIDTH cycles,
// reads the register back, compares with the accepted word and holds the
// result until the consumer takes it.
//   clk, rst     : clock and synchronous active-high reset
//   bus          : producer/consumer handshakes (slave modport)
//   ser_bit      : serial data to the shift register input
//   shift_en     : shift enable to the shift register
//   sr_q         : shift register parallel output
//   words_done   : completed transfers, wraps
//   mismatch_cnt : mismatched transfers, saturates at all-ones
module shift_reg_seq_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_reg_seq_ctrl_if.slave  bus,
    output logic                 ser_bit,
    output logic                 shift_en,
    input  logic [WIDTH-1:0]     sr_q,
    output logic [CNT_W-1:0]     words_done,
    output logic [CNT_W-1:0]     mismatch_cnt
);
    localparam int K_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] word_q;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   bit_idx;
    logic             match;

    // MSB-first: bit index counts down as k counts up.
    assign bit_idx = K_W'(WIDTH - 1) - k;
    assign match   = (sr_q == word_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and shift-register controls decode registered state only.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        shift_en      = 1'b0;
        ser_bit       = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                ser_bit  = word_q[bit_idx];
                if (k == K_W'(WIDTH - 1)) state_next = CHECK;
            end
            CHECK: begin
                state_next = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q        <= '0;
            k             <= '0;
            bus.out_word  <= '0;
            bus.out_match <= 1'b0;
            words_done    <= '0;
            mismatch_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word_q <= bus.in_word;
                        k      <= '0;
                    end
                end
                SHIFT: begin
                    k <= k + 1'b1;
                end
                CHECK: begin
                    bus.out_word  <= sr_q;
                    bus.out_match <= match;
                    if (!match && (mismatch_cnt != '1)) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) words_done <= words_done + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
